// File: rtl/uart_txfeed.sv
// Byte FIFO that feeds a uart_m transmitter: it pops one byte per load pulse and
// paces the pulses from the transmitter's txbusy handshake, with a timeout.
module uart_txfeed #(
    parameter int AW      = 4,
    parameter int BUSYTMO = 15
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cte1,
    input  logic          wr,
    input  logic [7:0]    wd,
    input  logic          flush,
    input  logic          txbusy,
    output logic          load,
    output logic [7:0]    d,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam int DEPTH = 2 ** AW;
    localparam int TW    = $clog2(BUSYTMO + 1);

    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSYTMO - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAITBUSY,
        WAITDONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_q;
    logic            ovf_q;

    logic            pop;
    logic            wr_acc;

    logic            load_p1;
    logic [7:0]      d_p1;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign ovf   = ovf_q;
    assign load  = load_p1;
    assign d     = d_p1;

    // The head byte leaves the FIFO on the enabled edge that ends the LOAD cycle,
    // so a stalled LOAD (cte1=0) can never pop twice.
    assign pop    = (state_q == LOAD);
    assign wr_acc = wr && (!full || pop);

    always_ff @(posedge clk) begin
        if (cte1 && !flush && wr_acc) begin
            mem[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (cte1) begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_acc && !pop) begin
                    level_q <= level_q + 1'b1;
                end else if (pop && !wr_acc) begin
                    level_q <= level_q - 1'b1;
                end
                if (wr && !wr_acc) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (!empty && !txbusy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAITBUSY;
                timer_d = '0;
            end
            WAITBUSY: begin
                if (txbusy) begin
                    state_d = WAITDONE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    // transmitter never acknowledged: treat the byte as sent
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAITDONE: begin
                if (!txbusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else if (cte1) begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Output register stage: load/d registered alongside the LOAD state entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_p1 <= 1'b0;
            d_p1    <= 8'h00;
        end else if (cte1) begin
            load_p1 <= (state_d == LOAD);
            if (state_d == LOAD) begin
                d_p1 <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_txfeed.sv
// Directed bench for uart_txfeed: written bytes go into a scoreboard queue and a
// monitor pops and compares them on every load pulse; a txbusy model plays uart_m.
module tb_uart_txfeed;

    localparam int AW = 4;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic          cte1   = 1'b1;
    logic          wr     = 1'b0;
    logic [7:0]    wd     = 8'h00;
    logic          flush  = 1'b0;
    logic          txbusy = 1'b0;
    logic          load;
    logic [7:0]    d;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;

    uart_txfeed #(.AW(AW), .BUSYTMO(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .cte1   (cte1),
        .wr     (wr),
        .wd     (wd),
        .flush  (flush),
        .txbusy (txbusy),
        .load   (load),
        .d      (d),
        .full   (full),
        .empty  (empty),
        .level  (level),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    // txbusy model: 0 = tied low, 1 = held high, 2 = rise 2 cycles after load, fall 20 later
    int bmode = 2;
    int bctr  = -1;
    bit kick  = 1'b0;

    int en_edges     = 0;
    int last_pulse   = -100;
    int last_spacing = 0;
    int n_pulses     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: a load pulse is an enabled edge after which load is high
    always @(posedge clk) begin
        #1;
        if (resetn) begin
            if (cte1) en_edges++;
            if (load && cte1) begin
                n_pulses++;
                kick = 1'b1;
                check("load_while_busy", int'(txbusy), 0);
                check("load_spacing_ge3", int'((en_edges - last_pulse) >= 3), 1);
                last_spacing = en_edges - last_pulse;
                last_pulse   = en_edges;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: got d=0x%0h expected no load", d);
                end else begin
                    check("load_data", int'(d), int'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bmode == 0) begin
            txbusy = 1'b0;
            bctr   = -1;
            kick   = 1'b0;
        end else if (bmode == 1) begin
            txbusy = 1'b1;
            bctr   = -1;
            kick   = 1'b0;
        end else begin
            if (kick) begin
                kick = 1'b0;
                bctr = 0;
            end else if (bctr >= 0) begin
                bctr++;
            end
            if (bctr == 2) txbusy = 1'b1;
            else if (bctr == 22) begin
                txbusy = 1'b0;
                bctr   = -1;
            end else if (bctr < 0) txbusy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b, input bit accept);
        wr = 1'b1;
        wd = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check("drain_done", exp_q.size(), 0);
        exp_q.delete();
        tick(30);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int i;
        int c;

        #3 resetn = 1'b0;
        tick(3);
        check("rst_level", int'(level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_load", int'(load), 0);
        check("rst_d", int'(d), 8'h00);
        resetn = 1'b1;
        tick(2);

        // single byte and first-load latency
        p0 = n_pulses;
        wr = 1'b1;
        wd = 8'hc1;
        exp_q.push_back(8'hc1);
        @(negedge clk);
        wr = 1'b0;
        check("lat_level1", int'(level), 1);
        check("lat_load_c0", int'(load), 0);
        @(negedge clk);
        check("lat_load_c1", int'(load), 1);
        check("lat_d", int'(d), 8'hc1);
        drain(200);
        check("single_pulses", n_pulses - p0, 1);
        check("single_level0", int'(level), 0);
        check("single_empty", int'(empty), 1);
        check("single_d_held", int'(d), 8'hc1);

        // burst of three back-to-back writes
        p0 = n_pulses;
        put(8'hc1, 1'b1);
        put(8'h4e, 1'b1);
        put(8'h55, 1'b1);
        drain(500);
        check("burst_pulses", n_pulses - p0, 3);
        check("burst_empty", int'(empty), 1);

        // fill and overflow with the transmitter held busy
        bmode = 1;
        tick(2);
        for (int k = 0; k < 16; k++) put(8'(k), 1'b1);
        check("fill_full", int'(full), 1);
        check("fill_level16", int'(level), 16);
        check("fill_ovf0", int'(ovf), 0);
        put(8'h10, 1'b0);
        check("ovf_level16", int'(level), 16);
        check("ovf_set", int'(ovf), 1);
        check("ovf_full", int'(full), 1);
        p0 = n_pulses;
        bmode = 2;
        drain(2000);
        check("ovf_pulses", n_pulses - p0, 16);
        check("ovf_drain_empty", int'(empty), 1);
        check("ovf_sticky", int'(ovf), 1);

        // flush with a same-cycle write
        bmode = 1;
        tick(2);
        put(8'haa, 1'b0);
        put(8'hbb, 1'b0);
        put(8'hcc, 1'b0);
        check("flush_pre_level", int'(level), 3);
        check("flush_pre_ovf", int'(ovf), 1);
        wr    = 1'b1;
        wd    = 8'hdd;
        flush = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        flush = 1'b0;
        check("flush_level", int'(level), 0);
        check("flush_empty", int'(empty), 1);
        check("flush_ovf", int'(ovf), 0);
        check("flush_load", int'(load), 0);
        p0 = n_pulses;
        bmode = 2;
        tick(60);
        check("flush_no_loads", n_pulses - p0, 0);

        // 40 bytes through the FIFO, wrapping the pointers twice
        i = 0;
        c = 0;
        while (i < 40 && c < 5000) begin
            check("wrap_level_le16", int'(level <= 16), 1);
            if (!full) begin
                wr = 1'b1;
                wd = 8'(i * 7 + 3);
                exp_q.push_back(wd);
                i++;
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        wr = 1'b0;
        check("wrap_written", i, 40);
        drain(3000);
        check("wrap_empty", int'(empty), 1);

        // busy timeout: txbusy never rises
        bmode = 0;
        tick(2);
        p0 = n_pulses;
        put(8'h4e, 1'b1);
        put(8'h55, 1'b1);
        drain(200);
        check("tmo_pulses", n_pulses - p0, 2);
        check("tmo_spacing", last_spacing, 17);

        // clock enable low while in LOAD
        put(8'ha5, 1'b1);
        put(8'h3c, 1'b1);
        check("hold_load_seen", int'(load), 1);
        cte1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_load", int'(load), 1);
            check("hold_level", int'(level), 2);
            check("hold_d", int'(d), 8'ha5);
        end
        cte1 = 1'b1;
        @(negedge clk);
        check("hold_release_load", int'(load), 0);
        check("hold_release_level", int'(level), 1);
        drain(200);

        // async reset while waiting for the transmitter to finish
        bmode = 2;
        tick(2);
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        put(8'h33, 1'b1);
        put(8'h44, 1'b1);
        c = 0;
        while (!txbusy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("rst2_busy_seen", int'(txbusy), 1);
        tick(2);
        check("rst2_pre_level", int'(level), 3);
        #2 resetn = 1'b0;
        #1;
        check("rst2_level", int'(level), 0);
        check("rst2_empty", int'(empty), 1);
        check("rst2_load", int'(load), 0);
        check("rst2_ovf", int'(ovf), 0);
        check("rst2_d", int'(d), 8'h00);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        p0 = n_pulses;
        tick(60);
        check("rst2_no_loads", n_pulses - p0, 0);
        check("rst2_empty_after", int'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
